// File: rtl/alu_sequencer.sv
// Three-state command sequencer that feeds an external ALU from a 4-entry register file
// and writes the result and flags back one cycle after capturing them.
module alu_sequencer #(
   parameter int unsigned NREGS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_op,
   input  logic [1:0] cmd_rd,
   input  logic [1:0] cmd_rs1,
   input  logic [1:0] cmd_rs2,
   input  logic       cmd_imm,
   input  logic [7:0] cmd_data,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [3:0] alu_op,
   input  logic [7:0] alu_result,
   input  logic       alu_zero,
   input  logic       alu_carry,
   input  logic       alu_ovf,
   output logic       done,
   output logic       err,
   output logic [2:0] flags,
   input  logic [1:0] rd_addr,
   output logic [7:0] rd_data
);

   typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

   state_e     state_q, state_d;
   logic [7:0] a_q, a_d;
   logic [7:0] b_q, b_d;
   logic [3:0] op_q, op_d;
   logic [1:0] rd_q, rd_d;
   logic [7:0] res_q, res_d;
   logic [2:0] cap_flags_q, cap_flags_d;
   logic [2:0] flags_q, flags_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic [7:0] regs_q [NREGS];
   logic [7:0] regs_d [NREGS];

   assign cmd_ready = (state_q == StIdle) && !rst;

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      rd_d        = rd_q;
      res_d       = res_q;
      cap_flags_d = cap_flags_q;
      flags_d     = flags_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      regs_d      = regs_q;
      unique case (state_q)
         StIdle: begin
            if (cmd_valid && cmd_ready) begin
               a_d     = regs_q[cmd_rs1];
               b_d     = cmd_imm ? cmd_data : regs_q[cmd_rs2];
               op_d    = cmd_op;
               rd_d    = cmd_rd;
               state_d = StExec;
            end
         end
         StExec: begin
            res_d       = alu_result;
            cap_flags_d = {alu_zero, alu_carry, alu_ovf};
            done_d      = 1'b1;
            // Op codes 1100-1111 are undefined; flag them so WB suppresses the write.
            err_d       = (op_q[3:2] == 2'b11);
            state_d     = StWb;
         end
         StWb: begin
            if (!err_q) begin
               regs_d[rd_q] = res_q;
               flags_d      = cap_flags_q;
            end
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         rd_q        <= '0;
         res_q       <= '0;
         cap_flags_q <= '0;
         flags_q     <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         regs_q      <= '{default: '0};
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         rd_q        <= rd_d;
         res_q       <= res_d;
         cap_flags_q <= cap_flags_d;
         flags_q     <= flags_d;
         done_q      <= done_d;
         err_q       <= err_d;
         regs_q      <= regs_d;
      end
   end

   assign alu_a   = a_q;
   assign alu_b   = b_q;
   assign alu_op  = op_q;
   assign done    = done_q;
   assign err     = err_q;
   assign flags   = flags_q;
   assign rd_data = regs_q[rd_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a behavioural ALU drives alu_result/flags, and an array-based
// register-file model predicts every completed command.
module tb_alu_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_op;
   logic [1:0] cmd_rd, cmd_rs1, cmd_rs2;
   logic       cmd_imm;
   logic [7:0] cmd_data;
   logic [7:0] alu_a, alu_b;
   logic [3:0] alu_op;
   logic [7:0] alu_result;
   logic       alu_zero, alu_carry, alu_ovf;
   logic       done, err;
   logic [2:0] flags;
   logic [1:0] rd_addr;
   logic [7:0] rd_data;

   int tests_run = 0;
   int tests_failed = 0;

   logic [7:0] m_r [4];
   logic [2:0] m_flags;

   always #5 clk = ~clk;

   alu_sequencer #(.NREGS(4)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
      .cmd_data(cmd_data), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
      .done(done), .err(err), .flags(flags), .rd_addr(rd_addr), .rd_data(rd_data)
   );

   // Returns {result, zero, carry, overflow}; carry is borrow for SUB, high byte nonzero for MUL.
   function automatic logic [10:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] op);
      int unsigned ua, ub, full;
      logic [7:0]  r;
      logic        c, v;
      ua = a; ub = b; full = 0; r = 8'd0; c = 1'b0; v = 1'b0;
      case (op)
         4'd0:  begin full = ua + ub; r = full[7:0]; c = full > 255;
                      v = (a[7] == b[7]) && (r[7] != a[7]); end
         4'd1:  begin full = ua + 256 - ub; r = full[7:0]; c = ua < ub;
                      v = (a[7] != b[7]) && (r[7] != a[7]); end
         4'd2:  r = a & b;
         4'd3:  r = a | b;
         4'd4:  r = a ^ b;
         4'd5:  r = ~a;
         4'd6:  begin full = ua * 2; r = full[7:0]; c = a[7]; end
         4'd7:  begin r = 8'(ua / 2); c = a[0]; end
         4'd8:  begin full = ua + 1; r = full[7:0]; c = full > 255; end
         4'd9:  begin full = ua + 255; r = full[7:0]; c = (ua == 0); end
         4'd10: r = b;
         4'd11: begin full = ua * ub; r = full[7:0]; c = full > 255; end
         default: r = 8'd0;
      endcase
      return {r, (r == 8'd0), c, v};
   endfunction

   assign {alu_result, alu_zero, alu_carry, alu_ovf} = alu_ref(alu_a, alu_b, alu_op);

   // Reference update: operands are read before the write, illegal ops change nothing.
   task automatic model_exec(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                             input logic [1:0] rs2, input logic imm, input logic [7:0] data,
                             output logic [7:0] ea, output logic [7:0] eb, output logic eerr);
      logic [10:0] o;
      ea = m_r[rs1];
      eb = imm ? data : m_r[rs2];
      eerr = (op >= 4'd12);
      o = alu_ref(ea, eb, op);
      if (!eerr) begin
         m_r[rd] = o[10:3];
         m_flags = o[2:0];
      end
   endtask

   // Drives one command and samples done at 1, 2 and 3 edges after it; noise on cmd_valid
   // while busy must be ignored.
   task automatic do_cmd(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic imm, input logic [7:0] data,
                         output logic o_ready, output logic [2:0] o_done, output logic o_err,
                         output logic [7:0] o_a, output logic [7:0] o_b, output logic [3:0] o_op);
      @(negedge clk);
      cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm; cmd_data = data;
      cmd_valid = 1'b1;
      #1 o_ready = cmd_ready;
      @(posedge clk);
      #1 o_done[0] = done;
      cmd_valid = 1'($urandom_range(1)); cmd_data = 8'($urandom); cmd_rs1 = 2'($urandom);
      cmd_rs2 = 2'($urandom); cmd_imm = 1'($urandom); cmd_op = 4'($urandom);
      @(posedge clk);
      #1 o_done[1] = done; o_err = err; o_a = alu_a; o_b = alu_b; o_op = alu_op;
      cmd_valid = 1'($urandom_range(1)); cmd_data = 8'($urandom);
      @(posedge clk);
      #1 o_done[2] = done;
      cmd_valid = 1'b0;
   endtask

   task automatic read_reg(input logic [1:0] addr, output logic [7:0] val);
      rd_addr = addr;
      #1 val = rd_data;
   endtask

   task automatic load_imm(input logic [1:0] rd, input logic [7:0] val);
      logic r, e; logic [2:0] d; logic [7:0] a, b, ea, eb; logic [3:0] o; logic ee;
      do_cmd(4'd10, rd, 2'd0, 2'd0, 1'b1, val, r, d, e, a, b, o);
      model_exec(4'd10, rd, 2'd0, 2'd0, 1'b1, val, ea, eb, ee);
   endtask

   task automatic test_reset();
      logic [7:0] v;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0;
      cmd_imm = 1'b0; cmd_data = '0; rd_addr = '0;
      foreach (m_r[i]) m_r[i] = 8'd0;
      m_flags = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if ({cmd_ready, done, err, flags, alu_a, alu_b, alu_op} !== 25'd0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got ready=%b done=%b err=%b flags=%b a=%0d b=%0d op=%0d, want all 0",
                  cmd_ready, done, err, flags, alu_a, alu_b, alu_op);
      end
      for (int i = 0; i < 4; i++) begin
         read_reg(2'(i), v);
         tests_run++;
         if (v !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_reg%0d: got %0d want 0", i, v);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      tests_run++;
      if (cmd_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
      end
   endtask

   task automatic test_imm_load();
      logic r, e; logic [2:0] d; logic [7:0] a, b, v; logic [3:0] o; logic [7:0] ea, eb; logic ee;
      do_cmd(4'd0, 2'd0, 2'd0, 2'd0, 1'b1, 8'd10, r, d, e, a, b, o);
      model_exec(4'd0, 2'd0, 2'd0, 2'd0, 1'b1, 8'd10, ea, eb, ee);
      read_reg(2'd0, v);
      tests_run++;
      if ({r, d, e} !== 5'b1_010_0) begin
         tests_failed++;
         $display("FAIL imm_load_handshake: got ready=%b done_seq=%b err=%b want 1 010 0", r, d, e);
      end
      tests_run++;
      if (v !== 8'd10 || flags !== 3'b000) begin
         tests_failed++;
         $display("FAIL imm_load_result: got R0=%0d flags=%b want 10 000", v, flags);
      end
   endtask

   task automatic test_chained_add();
      logic r, e; logic [2:0] d; logic [7:0] a, b, v; logic [3:0] o; logic [7:0] ea, eb; logic ee;
      load_imm(2'd0, 8'd200);
      load_imm(2'd1, 8'd100);
      do_cmd(4'd0, 2'd2, 2'd0, 2'd1, 1'b0, 8'd0, r, d, e, a, b, o);
      model_exec(4'd0, 2'd2, 2'd0, 2'd1, 1'b0, 8'd0, ea, eb, ee);
      read_reg(2'd2, v);
      tests_run++;
      if (a !== 8'd200 || b !== 8'd100 || o !== 4'd0) begin
         tests_failed++;
         $display("FAIL chained_add_operands: got a=%0d b=%0d op=%0d want 200 100 0", a, b, o);
      end
      tests_run++;
      if (v !== 8'd44 || flags !== 3'b010) begin
         tests_failed++;
         $display("FAIL chained_add_result: got R2=%0d flags=%b want 44 010", v, flags);
      end
   endtask

   task automatic test_back_to_back();
      logic r, e; logic [2:0] d; logic [7:0] a, b, v; logic [3:0] o; logic [7:0] ea, eb; logic ee;
      logic [6:0] rdy_seq;
      load_imm(2'd0, 8'd10);
      load_imm(2'd1, 8'd20);
      do_cmd(4'd1, 2'd0, 2'd0, 2'd1, 1'b0, 8'd0, r, d, e, a, b, o);
      model_exec(4'd1, 2'd0, 2'd0, 2'd1, 1'b0, 8'd0, ea, eb, ee);
      read_reg(2'd0, v);
      tests_run++;
      if (v !== 8'd246 || flags[1] !== 1'b1) begin
         tests_failed++;
         $display("FAIL in_place_sub: got R0=%0d carry=%b want 246 1", v, flags[1]);
      end
      // Hold the same SUB valid for 7 cycles: accepts must land on cycles 0, 3 and 6.
      @(negedge clk);
      cmd_op = 4'd1; cmd_rd = 2'd0; cmd_rs1 = 2'd0; cmd_rs2 = 2'd1; cmd_imm = 1'b0;
      cmd_valid = 1'b1;
      for (int k = 0; k < 7; k++) begin
         if (k > 0) @(negedge clk);
         rdy_seq[k] = cmd_ready;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (3) model_exec(4'd1, 2'd0, 2'd0, 2'd1, 1'b0, 8'd0, ea, eb, ee);
      repeat (3) @(posedge clk);
      #1 read_reg(2'd0, v);
      tests_run++;
      if (rdy_seq !== 7'b1001001) begin
         tests_failed++;
         $display("FAIL back_to_back_accepts: got ready pattern %b want 1001001", rdy_seq);
      end
      tests_run++;
      if (v !== m_r[0] || flags !== m_flags) begin
         tests_failed++;
         $display("FAIL back_to_back_result: got R0=%0d flags=%b want %0d %b",
                  v, flags, m_r[0], m_flags);
      end
   endtask

   task automatic test_illegal();
      logic r, e; logic [2:0] d; logic [7:0] a, b, v; logic [3:0] o; logic [2:0] f0;
      logic [7:0] ea, eb; logic ee;
      load_imm(2'd3, 8'd5);
      f0 = m_flags;
      do_cmd(4'd15, 2'd3, 2'd0, 2'd1, 1'b0, 8'd0, r, d, e, a, b, o);
      model_exec(4'd15, 2'd3, 2'd0, 2'd1, 1'b0, 8'd0, ea, eb, ee);
      read_reg(2'd3, v);
      tests_run++;
      if (d !== 3'b010 || e !== 1'b1 || o !== 4'd15) begin
         tests_failed++;
         $display("FAIL illegal_pulse: got done_seq=%b err=%b op=%0d want 010 1 15", d, e, o);
      end
      tests_run++;
      if (v !== 8'd5 || flags !== f0) begin
         tests_failed++;
         $display("FAIL illegal_no_write: got R3=%0d flags=%b want 5 %b", v, flags, f0);
      end
   endtask

   task automatic test_mul_reset();
      logic r, e; logic [2:0] d; logic [7:0] a, b, v; logic [3:0] o; logic [7:0] ea, eb; logic ee;
      logic saw_done;
      load_imm(2'd0, 8'd20);
      do_cmd(4'd11, 2'd0, 2'd0, 2'd0, 1'b1, 8'd20, r, d, e, a, b, o);
      model_exec(4'd11, 2'd0, 2'd0, 2'd0, 1'b1, 8'd20, ea, eb, ee);
      read_reg(2'd0, v);
      tests_run++;
      if (v !== 8'd144 || flags[1] !== 1'b1) begin
         tests_failed++;
         $display("FAIL mul_result: got R0=%0d carry=%b want 144 1", v, flags[1]);
      end
      @(negedge clk);
      cmd_op = 4'd0; cmd_rd = 2'd1; cmd_rs1 = 2'd0; cmd_imm = 1'b1; cmd_data = 8'd1;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      rst = 1'b1;
      #1;
      tests_run++;
      if ({cmd_ready, done, err, flags, alu_a, alu_b, alu_op} !== 25'd0) begin
         tests_failed++;
         $display("FAIL exec_reset_outputs: got ready=%b done=%b flags=%b a=%0d op=%0d want all 0",
                  cmd_ready, done, flags, alu_a, alu_op);
      end
      foreach (m_r[i]) m_r[i] = 8'd0;
      m_flags = 3'd0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      tests_run++;
      if (cmd_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL exec_reset_ready: got %b want 1", cmd_ready);
      end
      saw_done = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1 saw_done = saw_done | done;
      end
      tests_run++;
      if (saw_done !== 1'b0) begin
         tests_failed++;
         $display("FAIL exec_reset_no_done: got done seen=%b want 0", saw_done);
      end
      for (int i = 0; i < 4; i++) begin
         read_reg(2'(i), v);
         tests_run++;
         if (v !== 8'd0) begin
            tests_failed++;
            $display("FAIL exec_reset_reg%0d: got %0d want 0", i, v);
         end
      end
   endtask

   task automatic test_random();
      logic r, e; logic [2:0] d; logic [7:0] a, b, v; logic [3:0] o;
      logic [7:0] ea, eb; logic ee;
      logic [3:0] op; logic [1:0] rd, rs1, rs2; logic imm; logic [7:0] data;
      for (int n = 0; n < 60; n++) begin
         op = 4'($urandom); rd = 2'($urandom); rs1 = 2'($urandom); rs2 = 2'($urandom);
         imm = 1'($urandom); data = 8'($urandom);
         do_cmd(op, rd, rs1, rs2, imm, data, r, d, e, a, b, o);
         model_exec(op, rd, rs1, rs2, imm, data, ea, eb, ee);
         tests_run++;
         if ({r, d, e} !== {1'b1, 3'b010, ee} || a !== ea || b !== eb || o !== op) begin
            tests_failed++;
            $display("FAIL rand%0d_issue: got rdy=%b done=%b err=%b a=%0d b=%0d op=%0d want 1 010 %b %0d %0d %0d",
                     n, r, d, e, a, b, o, ee, ea, eb, op);
         end
         read_reg(rd, v);
         tests_run++;
         if (v !== m_r[rd] || flags !== m_flags) begin
            tests_failed++;
            $display("FAIL rand%0d_writeback: got R%0d=%0d flags=%b want %0d %b",
                     n, rd, v, flags, m_r[rd], m_flags);
         end
      end
   endtask

   initial begin
      test_reset();
      test_imm_load();
      test_chained_add();
      test_back_to_back();
      test_illegal();
      test_mul_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
